fpu_issue_seq: RTL and testbench

Issue/sequencing stage directly upstream of the combinational FPU datapath.
- Accepts one FP operation from the pipeline through a valid/ready handshake.
- Registers the operands and opcode and holds them stable on BusA/BusB/FPUCtrl for the op's fixed latency.
- Captures BusO into a result register, then offers it to writeback through a second valid/ready handshake.
- Drives Busy for the pipeline stall logic.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_lat_lut.sv | 28 ++
 rtl/fpu_issue_seq.sv | 150 +++++++++++++++
 tb/tb_fpu_issue_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Definitions shared by the FPU datapath, the issue stage, the hazard unit and writeback:
// opcode encoding, issue-stage FSM states and default operation latencies.
package fpu_pkg;

  localparam logic [3:0] ADD32 = 4'b0000;
  localparam logic [3:0] SUB32 = 4'b0001;
  localparam logic [3:0] MUL32 = 4'b0010;
  localparam logic [3:0] DIV32 = 4'b0011;
  localparam logic [3:0] ADD64 = 4'b0100;
  localparam logic [3:0] SUB64 = 4'b0101;
  localparam logic [3:0] MUL64 = 4'b0110;
  localparam logic [3:0] DIV64 = 4'b0111;

  localparam int DEF_LAT_ADD   = 2;
  localparam int DEF_LAT_MUL32 = 3;
  localparam int DEF_LAT_MUL64 = 5;
  localparam int DEF_LAT_DIV32 = 12;
  localparam int DEF_LAT_DIV64 = 24;
  localparam int DEF_CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } issue_state_e;

  // Every opcode with the top bit set is undefined.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/fpu_lat_lut.sv
// Opcode to (latency - 1) map; shared by the issue stage and the hazard unit.
module fpu_lat_lut
  import fpu_pkg::*;
#(
  parameter int LAT_ADD   = DEF_LAT_ADD,
  parameter int LAT_MUL32 = DEF_LAT_MUL32,
  parameter int LAT_MUL64 = DEF_LAT_MUL64,
  parameter int LAT_DIV32 = DEF_LAT_DIV32,
  parameter int LAT_DIV64 = DEF_LAT_DIV64,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic [3:0]       op,
  output logic [CNT_W-1:0] lat_m1
);

  always_comb begin
    // Undefined opcodes complete after a single cycle.
    case (op)
      ADD32, SUB32, ADD64, SUB64: lat_m1 = CNT_W'(LAT_ADD - 1);
      MUL32:                      lat_m1 = CNT_W'(LAT_MUL32 - 1);
      MUL64:                      lat_m1 = CNT_W'(LAT_MUL64 - 1);
      DIV32:                      lat_m1 = CNT_W'(LAT_DIV32 - 1);
      DIV64:                      lat_m1 = CNT_W'(LAT_DIV64 - 1);
      default:                    lat_m1 = '0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue/sequencing stage in front of the combinational FPU: holds operands for the
// op's latency, captures the result and offers it to writeback.
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int LAT_ADD   = DEF_LAT_ADD,
  parameter int LAT_MUL32 = DEF_LAT_MUL32,
  parameter int LAT_MUL64 = DEF_LAT_MUL64,
  parameter int LAT_DIV32 = DEF_LAT_DIV32,
  parameter int LAT_DIV64 = DEF_LAT_DIV64,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        Flush,
  input  logic        IssueValid,
  output logic        IssueReady,
  input  logic [63:0] OpA,
  input  logic [63:0] OpB,
  input  logic [3:0]  OpCtrl,
  input  logic [4:0]  OpDest,
  output logic [63:0] BusA,
  output logic [63:0] BusB,
  output logic [3:0]  FPUCtrl,
  input  logic [63:0] BusO,
  output logic        ResValid,
  input  logic        ResReady,
  output logic [63:0] ResData,
  output logic [4:0]  ResDest,
  output logic        IllegalOp,
  output logic        Busy
);

  issue_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      bus_a_q, bus_a_d;
  logic [63:0]      bus_b_q, bus_b_d;
  logic [3:0]       fpu_ctrl_q, fpu_ctrl_d;
  logic [63:0]      res_data_q, res_data_d;
  logic [4:0]       res_dest_q, res_dest_d;
  logic             res_valid_q, res_valid_d;
  logic             illegal_q, illegal_d;

  logic [CNT_W-1:0] lat_m1;
  logic             issue_ready;
  logic             accept;

  fpu_lat_lut #(
    .LAT_ADD   (LAT_ADD),
    .LAT_MUL32 (LAT_MUL32),
    .LAT_MUL64 (LAT_MUL64),
    .LAT_DIV32 (LAT_DIV32),
    .LAT_DIV64 (LAT_DIV64),
    .CNT_W     (CNT_W)
  ) u_lat_lut (
    .op     (OpCtrl),
    .lat_m1 (lat_m1)
  );

  // A held result may retire and a new op be accepted on the same edge.
  assign issue_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && ResReady);
  assign accept      = IssueValid && issue_ready && !Flush;

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_a_d     = bus_a_q;
    bus_b_d     = bus_b_q;
    fpu_ctrl_d  = fpu_ctrl_q;
    res_data_d  = res_data_q;
    res_dest_d  = res_dest_q;
    res_valid_d = res_valid_q;
    illegal_d   = illegal_q;

    if (Flush) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
      illegal_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_EXEC: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            res_data_d  = op_is_illegal(fpu_ctrl_q) ? 64'd0 : BusO;
            illegal_d   = op_is_illegal(fpu_ctrl_q);
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ResReady) begin
            res_valid_d = 1'b0;
            illegal_d   = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Accept overrides the retire-to-IDLE above for back-to-back issue.
      if (accept) begin
        bus_a_d    = OpA;
        bus_b_d    = OpB;
        fpu_ctrl_d = OpCtrl;
        res_dest_d = OpDest;
        cnt_d      = lat_m1;
        state_d    = ST_EXEC;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all flops are reset since there is no array storage here.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_a_q     <= '0;
      bus_b_q     <= '0;
      fpu_ctrl_q  <= '0;
      res_data_q  <= '0;
      res_dest_q  <= '0;
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_a_q     <= bus_a_d;
      bus_b_q     <= bus_b_d;
      fpu_ctrl_q  <= fpu_ctrl_d;
      res_data_q  <= res_data_d;
      res_dest_q  <= res_dest_d;
      res_valid_q <= res_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign IssueReady = issue_ready;
  assign BusA       = bus_a_q;
  assign BusB       = bus_b_q;
  assign FPUCtrl    = fpu_ctrl_q;
  assign ResValid   = res_valid_q;
  assign ResData    = res_data_q;
  assign ResDest    = res_dest_q;
  assign IllegalOp  = illegal_q;
  assign Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Scoreboard bench for fpu_issue_seq: directed scenarios then randomized traffic,
// checked against a cycle-count reference model of the issue stage.
module tb_fpu_issue_seq;

  logic        CLK;
  logic        Reset_L;
  logic        Flush;
  logic        IssueValid;
  logic        IssueReady;
  logic [63:0] OpA, OpB;
  logic [3:0]  OpCtrl;
  logic [4:0]  OpDest;
  logic [63:0] BusA, BusB;
  logic [3:0]  FPUCtrl;
  logic [63:0] BusO;
  logic        ResValid;
  logic        ResReady;
  logic [63:0] ResData;
  logic [4:0]  ResDest;
  logic        IllegalOp;
  logic        Busy;

  fpu_issue_seq dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .Flush      (Flush),
    .IssueValid (IssueValid),
    .IssueReady (IssueReady),
    .OpA        (OpA),
    .OpB        (OpB),
    .OpCtrl     (OpCtrl),
    .OpDest     (OpDest),
    .BusA       (BusA),
    .BusB       (BusB),
    .FPUCtrl    (FPUCtrl),
    .BusO       (BusO),
    .ResValid   (ResValid),
    .ResReady   (ResReady),
    .ResData    (ResData),
    .ResDest    (ResDest),
    .IllegalOp  (IllegalOp),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Latency per opcode[2:0] for legal ops: ADD32 SUB32 MUL32 DIV32 ADD64 SUB64 MUL64 DIV64.
  int lat_tab [8] = '{2, 2, 3, 12, 2, 2, 5, 24};

  // Reference model: an op occupies the stage from accept until retired or flushed;
  // its result appears at the edge LAT cycles after the accept edge.
  bit          m_inflight = 0;
  bit          m_present  = 0;
  bit          m_accepted = 0;
  int          m_due      = 0;
  logic [63:0] m_a, m_b;
  logic [3:0]  m_ctrl;

  function automatic int lat_of(input logic [3:0] c);
    return c[3] ? 1 : lat_tab[c[2:0]];
  endfunction

  // Combinational FPU stand-in; returns 3.0f for 1.0f + 2.0f.
  function automatic logic [63:0] fpu_stub(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] c);
    if (c == 4'b0000 && a == 64'h3F80_0000 && b == 64'h4000_0000) return 64'h4040_0000;
    return (a ^ {b[31:0], b[63:32]}) + 64'(c) * 64'h9E37_79B9_7F4A_7C15;
  endfunction

  assign BusO = fpu_stub(BusA, BusB, FPUCtrl);

  function automatic bit model_ready();
    return !m_inflight || (m_present && ResReady);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit rdy);
    exp_t e;
    m_accepted = 0;
    if (Flush) begin
      if (m_inflight && !m_present && sb.size() > 0) void'(sb.pop_back());
      m_inflight = 0;
      m_present  = 0;
    end else begin
      if (m_present && ResReady) begin
        m_present  = 0;
        m_inflight = 0;
      end else if (m_inflight && !m_present && cyc == m_due) begin
        m_present = 1;
      end
      if (IssueValid && rdy) begin
        m_accepted = 1;
        m_inflight = 1;
        m_present  = 0;
        m_due      = cyc + lat_of(OpCtrl);
        m_a        = OpA;
        m_b        = OpB;
        m_ctrl     = OpCtrl;
        e.ill      = OpCtrl[3];
        e.data     = OpCtrl[3] ? 64'd0 : fpu_stub(OpA, OpB, OpCtrl);
        e.dest     = OpDest;
        sb.push_back(e);
      end
    end
  endtask

  task automatic model_reset();
    m_inflight = 0;
    m_present  = 0;
    m_accepted = 0;
    sb.delete();
  endtask

  // Advance one edge; inputs change 2 time units after the edge.
  task automatic tick();
    bit rdy;
    rdy = model_ready();
    @(posedge CLK);
    #2;
    cyc++;
    if (Reset_L) model_edge(rdy);
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] c, input logic [4:0] d);
    int guard;
    guard      = 0;
    IssueValid = 1'b1;
    OpA        = a;
    OpB        = b;
    OpCtrl     = c;
    OpDest     = d;
    do begin
      tick();
      guard++;
    end while (!m_accepted && guard < 100);
    IssueValid = 1'b0;
    if (!m_accepted) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: op %0h not accepted within %0d cycles", c, guard);
    end
  endtask

  task automatic measure(output int k);
    k = 0;
    while (!ResValid && k < 60) begin
      tick();
      k++;
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge CLK) begin
    if (Reset_L) begin
      check("issue_ready", 64'(IssueReady), 64'(model_ready()));
      check("res_valid", 64'(ResValid), 64'(m_present));
      check("busy", 64'(Busy), 64'(m_inflight));
      if (m_inflight) begin
        check("bus_a", BusA, m_a);
        check("bus_b", BusB, m_b);
        check("fpu_ctrl", 64'(FPUCtrl), 64'(m_ctrl));
      end
      if (ResValid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: data %0h with empty scoreboard (cycle %0d)",
                   ResData, cyc);
        end else begin
          check("res_data", ResData, sb[0].data);
          check("res_dest", 64'(ResDest), 64'(sb[0].dest));
          check("illegal_op", 64'(IllegalOp), 64'(sb[0].ill));
          if (ResReady || Flush) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    Reset_L    = 1'b0;
    Flush      = 1'b0;
    IssueValid = 1'b0;
    OpA        = '0;
    OpB        = '0;
    OpCtrl     = '0;
    OpDest     = '0;
    ResReady   = 1'b1;

    #3;
    check("rst_issue_ready", 64'(IssueReady), 64'd1);
    check("rst_res_valid", 64'(ResValid), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_bus_a", BusA, 64'd0);
    check("rst_res_data", ResData, 64'd0);
    tick();
    tick();
    Reset_L = 1'b1;

    // ADD32: 1.0f + 2.0f
    issue(64'h3F80_0000, 64'h4000_0000, 4'b0000, 5'd5);
    check("add32_ready_drop", 64'(IssueReady), 64'd0);
    measure(k);
    check("add32_latency", 64'(k), 64'd2);
    check("add32_data", ResData, 64'h4040_0000);
    check("add32_dest", 64'(ResDest), 64'd5);
    check("add32_illegal", 64'(IllegalOp), 64'd0);
    tick();

    // DIV64 with a stalled consumer, then back-to-back MUL32
    ResReady = 1'b0;
    issue(64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000, 4'b0111, 5'd17);
    measure(k);
    check("div64_latency", 64'(k), 64'd24);
    for (int i = 0; i < 10; i++) tick();
    check("div64_stall_valid", 64'(ResValid), 64'd1);
    ResReady = 1'b1;
    issue(64'h1234, 64'h5678, 4'b0010, 5'd9);
    measure(k);
    check("mul32_b2b_latency", 64'(k), 64'd3);
    tick();

    // Illegal opcode
    issue(64'hDEAD_BEEF, 64'hCAFE, 4'b1010, 5'd3);
    measure(k);
    check("illegal_latency", 64'(k), 64'd1);
    check("illegal_flag", 64'(IllegalOp), 64'd1);
    check("illegal_data", ResData, 64'd0);
    tick();

    // Flush during cycle 5 of a DIV32
    issue(64'h4120_0000, 64'h4000_0000, 4'b0011, 5'd11);
    for (int i = 0; i < 4; i++) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_idle", 64'(Busy), 64'd0);
    for (int i = 0; i < 15; i++) tick();
    check("flush_sb_empty", 64'(sb.size()), 64'd0);
    issue(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 4'b0100, 5'd30);
    measure(k);
    check("add64_after_flush", 64'(k), 64'd2);
    tick();

    // Async reset while holding a result
    ResReady = 1'b0;
    issue(64'h7777_0000_1111, 64'h2222_3333, 4'b0101, 5'd21);
    measure(k);
    tick();
    #1;
    Reset_L = 1'b0;
    #1;
    check("arst_res_valid", 64'(ResValid), 64'd0);
    check("arst_busy", 64'(Busy), 64'd0);
    check("arst_bus_a", BusA, 64'd0);
    check("arst_bus_b", BusB, 64'd0);
    check("arst_fpu_ctrl", 64'(FPUCtrl), 64'd0);
    check("arst_res_data", ResData, 64'd0);
    check("arst_res_dest", 64'(ResDest), 64'd0);
    check("arst_illegal", 64'(IllegalOp), 64'd0);
    check("arst_issue_ready", 64'(IssueReady), 64'd1);
    model_reset();
    tick();
    tick();
    Reset_L  = 1'b1;
    ResReady = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      IssueValid = ($urandom_range(0, 9) < 6);
      OpA        = {$urandom, $urandom};
      OpB        = {$urandom, $urandom};
      OpCtrl     = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7))
                                               : 4'($urandom_range(0, 7));
      OpDest     = 5'($urandom_range(0, 31));
      ResReady   = ($urandom_range(0, 9) < 7);
      Flush      = ($urandom_range(0, 49) == 0);
      tick();
    end
    IssueValid = 1'b0;
    Flush      = 1'b0;
    ResReady   = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_idle", 64'(Busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
